accum_writeback_ctrl: RTL

Output-side consumer of the buffered accumulate flags (`store_buffered`, `overwrite_buffered`) in the systolic-array datapath. Receives result rows from the array, overwrites or accumulates them into an internal DEPTH-row accumulator, and on a store tile drains the accumulated rows through a valid/ready stream toward the output buffer. It closes the loop on the flag buffering done at the feed side: flags are sampled per tile here and held until that tile's write-back completes.

---
 rtl/accum_writeback_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/accum_writeback_ctrl.sv
// Accumulate-and-write-back controller for systolic-array result rows.
// Rows are overwritten into or added onto a DEPTH-row register array. A tile
// flagged for store is then drained through a valid/ready stream. The tile
// flags are latched on the first row of each tile and held until that tile's
// write-back completes.
module accum_writeback_ctrl #(
  parameter int DIM   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_overwrite_buffered,
  input  logic              i_store_buffered,
  input  logic              i_sa_valid,
  input  logic [DIM*DW-1:0] i_sa_row,
  input  logic              i_sa_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DIM*DW-1:0] o_out_data,
  output logic              o_out_last,
  output logic              o_busy,
  output logic              o_tile_done,
  output logic              o_drop_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DIM*DW-1:0]   r_rows [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_tile_len;
  logic                r_tile_ow;
  logic                r_tile_st;
  logic                r_tile_done;
  logic                r_drop_err;

  logic                w_accept;
  logic                w_first;
  logic                w_ow;
  logic                w_st;
  logic                w_end;
  logic                w_hs;
  logic                w_last_row;
  logic                w_last_hs;
  logic [AW:0]         w_last_idx;
  logic [DIM*DW-1:0]   w_row_cur;
  logic [DIM*DW-1:0]   w_row_new;

  // The first row of a tile uses the flags presented with it, later rows use the latched copy
  assign w_accept   = (r_state == ACCUM) && i_sa_valid;
  assign w_first    = (r_wr_ptr == '0);
  assign w_ow       = w_first ? i_overwrite_buffered : r_tile_ow;
  assign w_st       = w_first ? i_store_buffered : r_tile_st;
  assign w_end      = i_sa_last || (r_wr_ptr == AW'(DEPTH - 1));
  assign w_last_idx = r_tile_len - (AW + 1)'(1);
  assign w_last_row = ({1'b0, r_rd_ptr} == w_last_idx);
  assign w_hs       = (r_state == DRAIN) && i_out_ready;
  assign w_last_hs  = w_hs && w_last_row;
  assign w_row_cur  = r_rows[r_wr_ptr];

  // Lane-wise overwrite or modulo-2^DW add. Carries never cross lanes.
  genvar gi;
  generate
    for (gi = 0; gi < DIM; gi++) begin : g_lane
      assign w_row_new[gi*DW +: DW] = w_ow ? i_sa_row[gi*DW +: DW]
                                           : w_row_cur[gi*DW +: DW] + i_sa_row[gi*DW +: DW];
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ACCUM;
    else       r_state <= w_state_next;
  end

  // Next-state decode: enter DRAIN at the end of a store tile, leave on the last handshake
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACCUM: if (w_accept && w_end && w_st) w_state_next = DRAIN;
      DRAIN: if (w_last_hs)                 w_state_next = ACCUM;
      default:                              w_state_next = ACCUM;
    endcase
  end

  // Accumulator array, pointers, tile flags and status flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) r_rows[i] <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_tile_len  <= '0;
      r_tile_ow   <= 1'b0;
      r_tile_st   <= 1'b0;
      r_tile_done <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      r_tile_done <= 1'b0;
      if (w_accept) begin
        r_rows[r_wr_ptr] <= w_row_new;
        r_tile_ow        <= w_ow;
        r_tile_st        <= w_st;
        if (w_end) begin
          r_tile_len <= {1'b0, r_wr_ptr} + (AW + 1)'(1);
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          if (!w_st) r_tile_done <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
      end
      if (w_hs) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_last_row) r_tile_done <= 1'b1;
      end
      // A row offered while draining is lost; remember that it happened
      if ((r_state == DRAIN) && i_sa_valid) r_drop_err <= 1'b1;
    end
  end

  assign o_out_valid = (r_state == DRAIN);
  assign o_busy      = (r_state == DRAIN);
  assign o_out_data  = (r_state == DRAIN) ? r_rows[r_rd_ptr] : '0;
  assign o_out_last  = (r_state == DRAIN) && w_last_row;
  assign o_tile_done = r_tile_done;
  assign o_drop_err  = r_drop_err;

endmodule
